// File: rtl/pio_out_pkg.sv
// pio_out_pkg: shared constants and types for the output PIO slave.
// Register word addresses, strobe FSM encoding and status bit positions.
package pio_out_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_OUTSET   = 2'd1;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd2;
  localparam logic [1:0] ADDR_STROBE   = 2'd3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } strobe_state_t;

  localparam int BUSY_BIT = 31;
  localparam int DONE_BIT = 30;

endpackage

// File: rtl/pio_strobe_timer.sv
// pio_strobe_timer: one-shot strobe generator with a down-counting length.
// A load with len>0 (re)starts an N-cycle pulse, len==0 aborts it.
// The sticky done flag exists only when PIO_OUT_IRQ_EN is defined;
// otherwise done is tied low.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | no pulse in progress, remaining is 0
//   ACTIVE | strobe high, remaining counts down to 1 then returns IDLE
module pio_strobe_timer
  import pio_out_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic             strobe
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_ACTIVE = ACTIVE;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] rem_nxt;

  // next state and count: a load always wins over the running count
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    if (load) begin
      if (len != '0) begin
        state_nxt = ST_ACTIVE;
        rem_nxt   = len;
      end else begin
        state_nxt = ST_IDLE;
        rem_nxt   = '0;
      end
    end else if (state == ST_ACTIVE) begin
      if (remaining == CNT_W'(1)) begin
        state_nxt = ST_IDLE;
        rem_nxt   = '0;
      end else begin
        rem_nxt = remaining - CNT_W'(1);
      end
    end
  end

  // state, counter and the strobe decode flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      strobe    <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      strobe    <= (state_nxt == ST_ACTIVE);
    end
  end

  assign busy = (state == ST_ACTIVE);

`ifdef PIO_OUT_IRQ_EN
  logic expire;

  // natural expiry only; an abort or a load on the same edge does not count
  assign expire = !load && (state == ST_ACTIVE) && (remaining == CNT_W'(1));

  // sticky done: set on expiry, cleared by any load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else if (load) begin
      done <= 1'b0;
    end else if (expire) begin
      done <= 1'b1;
    end
  end
`else
  assign done = 1'b0;
`endif

endmodule

// File: rtl/pio_out_strobe.sv
// pio_out_strobe: Avalon-MM output PIO with a timed one-shot strobe.
// Holds the DATA register (direct drive of out_port), decodes DATA /
// OUTSET / OUTCLEAR / STROBE writes and registers read data every cycle.
// Optional build macro: PIO_OUT_IRQ_EN adds the irq port (irq = done).
module pio_out_strobe
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             out_strobe
`ifdef PIO_OUT_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic             wr;
  logic             strobe_load;
  logic [WIDTH-1:0] data;
  logic [31:0]      rd_mux;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;
  logic             unused_wdata;

  assign wr          = chipselect & ~write_n;
  assign strobe_load = wr && (address == ADDR_STROBE);

  // only the low bits of writedata are used; fold the rest here
  assign unused_wdata = ^writedata;

  // DATA register: full load, bit set and bit clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        ADDR_DATA:     data <= writedata[WIDTH-1:0];
        ADDR_OUTSET:   data <= data | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR: data <= data & ~writedata[WIDTH-1:0];
        default:       data <= data;
      endcase
    end
  end

  assign out_port = data;

  pio_strobe_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (strobe_load),
    .len       (writedata[CNT_W-1:0]),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .strobe    (out_strobe)
  );

`ifdef PIO_OUT_IRQ_EN
  assign irq = done;
`endif

  // read mux; set/clear registers are write-only and read as zero
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = data;
      ADDR_STROBE: begin
        rd_mux[CNT_W-1:0] = remaining;
        rd_mux[BUSY_BIT]  = busy;
        rd_mux[DONE_BIT]  = done;
      end
      default: rd_mux = '0;
    endcase
  end

  // read data is registered every cycle regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule
